// File: rtl/rf_pkg.sv
// Shared encodings and default sizing for the register-file read stage.
// Operand select enums for src1/src2 plus an address-width helper.
package rf_pkg;

   localparam int unsigned DEF_NUM_LANES = 2;
   localparam int unsigned DEF_NUM_WB    = 2;
   localparam int unsigned DEF_XLEN      = 32;
   localparam int unsigned DEF_NREG      = 32;
   localparam int unsigned DEF_PAYLOAD_W = 64;

   typedef enum logic [1:0] {
      Src1Rf   = 2'd0,
      Src1Pc   = 2'd1,
      Src1Zero = 2'd2,
      Src1Cnt  = 2'd3
   } src1_sel_e;

   typedef enum logic [1:0] {
      Src2Rf       = 2'd0,
      Src2Imm      = 2'd1,
      Src2StableLo = 2'd2,
      Src2StableHi = 2'd3
   } src2_sel_e;

   // Keeps a one-entry register file from producing a zero-width address.
   function automatic int unsigned addr_w(input int unsigned nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Resolves one register read: r0 reads as zero, optional write-back forwarding.
// Forwarding is compiled in only when RF_BYPASS_EN is defined; hit is always reported.
module rf_bypass_mux
   import rf_pkg::*;
#(
   parameter int unsigned NUM_WB = DEF_NUM_WB,
   parameter int unsigned XLEN   = DEF_XLEN,
   parameter int unsigned AW     = 5
) (
   input  logic [AW-1:0]          addr,
   input  logic [NUM_WB-1:0]      wb_en,
   input  logic [NUM_WB*AW-1:0]   wb_addr,
   input  logic [NUM_WB*XLEN-1:0] wb_data,
   input  logic [XLEN-1:0]        rf_val,
   output logic [XLEN-1:0]        data,
   output logic                   hit
);

   logic [XLEN-1:0] fwd;

   // Later ports overwrite earlier ones, so the highest-index match wins.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int unsigned w = 0; w < NUM_WB; w++) begin
         if (wb_en[w] && (wb_addr[w*AW +: AW] == addr)) begin
            hit = 1'b1;
            fwd = wb_data[w*XLEN +: XLEN];
         end
      end
      if (addr == '0) begin
         hit = 1'b0;
      end
   end

`ifdef RF_BYPASS_EN
   assign data = (addr == '0) ? '0 : (hit ? fwd : rf_val);
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd;
   assign data = (addr == '0) ? '0 : rf_val;
`endif

endmodule

// File: rtl/regfile_read_stage.sv
// Register file plus one-deep registered operand-read stage for a multi-lane issue group.
// Define RF_BYPASS_EN to forward same-cycle write-backs instead of stalling on them.
module regfile_read_stage
   import rf_pkg::*;
#(
   parameter int unsigned NUM_LANES = DEF_NUM_LANES,
   parameter int unsigned NUM_WB    = DEF_NUM_WB,
   parameter int unsigned XLEN      = DEF_XLEN,
   parameter int unsigned NREG      = DEF_NREG,
   parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
   localparam int unsigned AW       = addr_w(NREG)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [NUM_WB-1:0]              wb_en,
   input  logic [NUM_WB*AW-1:0]           wb_addr,
   input  logic [NUM_WB*XLEN-1:0]         wb_data,
   input  logic [XLEN-1:0]                counter_id,
   input  logic [2*XLEN-1:0]              stable_counter,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_LANES-1:0]           in_lane_en,
   input  logic [NUM_LANES*AW-1:0]        in_rj,
   input  logic [NUM_LANES*AW-1:0]        in_rk,
   input  logic [NUM_LANES*2-1:0]         in_src1_sel,
   input  logic [NUM_LANES*2-1:0]         in_src2_sel,
   input  logic [NUM_LANES*XLEN-1:0]      in_pc,
   input  logic [NUM_LANES*XLEN-1:0]      in_imm,
   input  logic [NUM_LANES*PAYLOAD_W-1:0] in_payload,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_LANES-1:0]           out_lane_en,
   output logic [NUM_LANES*AW-1:0]        out_rj,
   output logic [NUM_LANES*AW-1:0]        out_rk,
   output logic [NUM_LANES*XLEN-1:0]      out_pc,
   output logic [NUM_LANES*XLEN-1:0]      out_imm,
   output logic [NUM_LANES*PAYLOAD_W-1:0] out_payload,
   output logic [NUM_LANES*XLEN-1:0]      out_op1,
   output logic [NUM_LANES*XLEN-1:0]      out_op2
);

   logic [XLEN-1:0]           rf_q [NREG];
   logic [NUM_LANES*XLEN-1:0] op1_d;
   logic [NUM_LANES*XLEN-1:0] op2_d;
   logic [NUM_LANES-1:0]      lane_hazard;
   logic                      hazard;
   logic                      accept;

   // Write-back ignores stall/flush; loop order lets the highest port win a tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            rf_q[r] <= '0;
         end
      end else begin
         for (int unsigned w = 0; w < NUM_WB; w++) begin
            if (wb_en[w] && (wb_addr[w*AW +: AW] != '0)) begin
               rf_q[wb_addr[w*AW +: AW]] <= wb_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [AW-1:0]   rj;
      logic [AW-1:0]   rk;
      logic [1:0]      s1;
      logic [1:0]      s2;
      logic [XLEN-1:0] rj_data;
      logic [XLEN-1:0] rk_data;
      logic            rj_hit;
      logic            rk_hit;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;

      assign rj = in_rj[l*AW +: AW];
      assign rk = in_rk[l*AW +: AW];
      assign s1 = in_src1_sel[l*2 +: 2];
      assign s2 = in_src2_sel[l*2 +: 2];

      rf_bypass_mux #(
         .NUM_WB (NUM_WB),
         .XLEN   (XLEN),
         .AW     (AW)
      ) u_mux_rj (
         .addr    (rj),
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .rf_val  (rf_q[rj]),
         .data    (rj_data),
         .hit     (rj_hit)
      );

      rf_bypass_mux #(
         .NUM_WB (NUM_WB),
         .XLEN   (XLEN),
         .AW     (AW)
      ) u_mux_rk (
         .addr    (rk),
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .rf_val  (rf_q[rk]),
         .data    (rk_data),
         .hit     (rk_hit)
      );

      always_comb begin
         op1 = '0;
         op2 = '0;
         unique case (src1_sel_e'(s1))
            Src1Rf:   op1 = rj_data;
            Src1Pc:   op1 = in_pc[l*XLEN +: XLEN];
            Src1Zero: op1 = '0;
            Src1Cnt:  op1 = counter_id;
            default:  op1 = '0;
         endcase
         unique case (src2_sel_e'(s2))
            Src2Rf:       op2 = rk_data;
            Src2Imm:      op2 = in_imm[l*XLEN +: XLEN];
            Src2StableLo: op2 = stable_counter[XLEN-1:0];
            Src2StableHi: op2 = stable_counter[2*XLEN-1:XLEN];
            default:      op2 = '0;
         endcase
         if (!in_lane_en[l]) begin
            op1 = '0;
            op2 = '0;
         end
      end

      assign op1_d[l*XLEN +: XLEN] = op1;
      assign op2_d[l*XLEN +: XLEN] = op2;
      assign lane_hazard[l] = in_lane_en[l] &&
                              (((s1 == Src1Rf) && rj_hit) || ((s2 == Src2Rf) && rk_hit));
   end

`ifdef RF_BYPASS_EN
   logic unused_lane_hazard;
   assign unused_lane_hazard = |lane_hazard;
   assign hazard = 1'b0;
`else
   // Without forwarding, hold the group one cycle until the array has the new value.
   assign hazard = |lane_hazard;
`endif

   assign in_ready = !flush && (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_lane_en <= '0;
         out_rj      <= '0;
         out_rk      <= '0;
         out_pc      <= '0;
         out_imm     <= '0;
         out_payload <= '0;
         out_op1     <= '0;
         out_op2     <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_lane_en <= '0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_lane_en <= in_lane_en;
         out_rj      <= in_rj;
         out_rk      <= in_rk;
         out_pc      <= in_pc;
         out_imm     <= in_imm;
         out_payload <= in_payload;
         out_op1     <= op1_d;
         out_op2     <= op2_d;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: expected groups queued at accept, compared on output.
// Works with or without RF_BYPASS_EN defined.
module tb_regfile_read_stage;

   localparam int unsigned NL   = 2;
   localparam int unsigned NW   = 2;
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned PW   = 64;
   localparam int unsigned AW   = 5;

   typedef struct packed {
      logic [NL-1:0]      lane_en;
      logic [NL*AW-1:0]   rj;
      logic [NL*AW-1:0]   rk;
      logic [NL*XLEN-1:0] pc;
      logic [NL*XLEN-1:0] imm;
      logic [NL*PW-1:0]   payload;
      logic [NL*XLEN-1:0] op1;
      logic [NL*XLEN-1:0] op2;
   } grp_t;

   logic                clk;
   logic                rst;
   logic                flush;
   logic [NW-1:0]       wb_en;
   logic [NW*AW-1:0]    wb_addr;
   logic [NW*XLEN-1:0]  wb_data;
   logic [XLEN-1:0]     counter_id;
   logic [2*XLEN-1:0]   stable_counter;
   logic                in_valid;
   logic                in_ready;
   logic [NL-1:0]       in_lane_en;
   logic [NL*AW-1:0]    in_rj;
   logic [NL*AW-1:0]    in_rk;
   logic [NL*2-1:0]     in_src1_sel;
   logic [NL*2-1:0]     in_src2_sel;
   logic [NL*XLEN-1:0]  in_pc;
   logic [NL*XLEN-1:0]  in_imm;
   logic [NL*PW-1:0]    in_payload;
   logic                out_valid;
   logic                out_ready;
   logic [NL-1:0]       out_lane_en;
   logic [NL*AW-1:0]    out_rj;
   logic [NL*AW-1:0]    out_rk;
   logic [NL*XLEN-1:0]  out_pc;
   logic [NL*XLEN-1:0]  out_imm;
   logic [NL*PW-1:0]    out_payload;
   logic [NL*XLEN-1:0]  out_op1;
   logic [NL*XLEN-1:0]  out_op2;

   int   n_vec;
   int   n_miss;
   grp_t exp_grp;
   grp_t held;
   grp_t sb_q[$];

   regfile_read_stage #(
      .NUM_LANES (NL),
      .NUM_WB    (NW),
      .XLEN      (XLEN),
      .NREG      (NREG),
      .PAYLOAD_W (PW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .wb_en          (wb_en),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .counter_id     (counter_id),
      .stable_counter (stable_counter),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_lane_en     (in_lane_en),
      .in_rj          (in_rj),
      .in_rk          (in_rk),
      .in_src1_sel    (in_src1_sel),
      .in_src2_sel    (in_src2_sel),
      .in_pc          (in_pc),
      .in_imm         (in_imm),
      .in_payload     (in_payload),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_lane_en    (out_lane_en),
      .out_rj         (out_rj),
      .out_rk         (out_rk),
      .out_pc         (out_pc),
      .out_imm        (out_imm),
      .out_payload    (out_payload),
      .out_op1        (out_op1),
      .out_op2        (out_op2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_group();
      in_lane_en  = '0;
      in_rj       = '0;
      in_rk       = '0;
      in_src1_sel = '0;
      in_src2_sel = '0;
      in_pc       = '0;
      in_imm      = '0;
      in_payload  = '0;
      exp_grp     = '0;
   endtask

   task automatic set_lane(input int l, input logic en, input logic [AW-1:0] rj,
                           input logic [AW-1:0] rk, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                           input logic [PW-1:0] pl, input logic [XLEN-1:0] e1,
                           input logic [XLEN-1:0] e2);
      in_lane_en[l]                 = en;
      in_rj[l*AW +: AW]             = rj;
      in_rk[l*AW +: AW]             = rk;
      in_src1_sel[l*2 +: 2]         = s1;
      in_src2_sel[l*2 +: 2]         = s2;
      in_pc[l*XLEN +: XLEN]         = pc;
      in_imm[l*XLEN +: XLEN]        = imm;
      in_payload[l*PW +: PW]        = pl;
      exp_grp.lane_en[l]            = en;
      exp_grp.rj[l*AW +: AW]        = rj;
      exp_grp.rk[l*AW +: AW]        = rk;
      exp_grp.pc[l*XLEN +: XLEN]    = pc;
      exp_grp.imm[l*XLEN +: XLEN]   = imm;
      exp_grp.payload[l*PW +: PW]   = pl;
      exp_grp.op1[l*XLEN +: XLEN]   = e1;
      exp_grp.op2[l*XLEN +: XLEN]   = e2;
   endtask

   task automatic set_wb(input int w, input logic en, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d);
      wb_en[w]               = en;
      wb_addr[w*AW +: AW]    = a;
      wb_data[w*XLEN +: XLEN] = d;
   endtask

   task automatic check_out(input string tag);
      grp_t e;
      n_vec++;
      assert (sb_q.size() > 0) else begin
         n_miss++;
         $error("FAIL %s sb_empty: observed 0 entries expected 1", tag);
      end
      check({tag, " out_valid"}, 256'(out_valid), 256'(1'b1));
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, " lane_en"}, 256'(out_lane_en), 256'(e.lane_en));
         check({tag, " rj"},      256'(out_rj),      256'(e.rj));
         check({tag, " rk"},      256'(out_rk),      256'(e.rk));
         check({tag, " pc"},      256'(out_pc),      256'(e.pc));
         check({tag, " imm"},     256'(out_imm),     256'(e.imm));
         check({tag, " payload"}, 256'(out_payload), 256'(e.payload));
         check({tag, " op1"},     256'(out_op1),     256'(e.op1));
         check({tag, " op2"},     256'(out_op2),     256'(e.op2));
      end
   endtask

   // Called at a negedge with the group already driven; accepts it and checks the result.
   task automatic accept_group(input string tag);
      in_valid = 1'b1;
      #1;
      check({tag, " in_ready"}, 256'(in_ready), 256'(1'b1));
      sb_q.push_back(exp_grp);
      tick();
      in_valid = 1'b0;
      check_out(tag);
   endtask

   initial begin
      n_vec          = 0;
      n_miss         = 0;
      rst            = 1'b1;
      flush          = 1'b0;
      wb_en          = '0;
      wb_addr        = '0;
      wb_data        = '0;
      counter_id     = 32'h42;
      stable_counter = 64'h1_0000_0002;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      clear_group();
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst out_valid",   256'(out_valid),   256'(1'b0));
      check("rst out_op1",     256'(out_op1),     256'(0));
      check("rst out_lane_en", 256'(out_lane_en), 256'(0));
      check("rst out_payload", 256'(out_payload), 256'(0));
      #1 check("rst in_ready", 256'(in_ready), 256'(1'b1));

      // r5 written, then read next cycle; counter and stable_counter selects on lane 1
      set_wb(0, 1'b1, 5, 32'h11);
      tick();
      wb_en = '0;
      clear_group();
      set_lane(0, 1'b1, 5, 0, 2'd0, 2'd2, 32'h100, 32'h0, 64'hA0A0_0000_0000_A0A0, 32'h11, 32'h2);
      set_lane(1, 1'b1, 0, 0, 2'd3, 2'd3, 32'h204, 32'h0, 64'hB1B1_0000_0000_B1B1, 32'h42, 32'h1);
      accept_group("r5_read");
      tick();
      check("drain out_valid", 256'(out_valid), 256'(1'b0));

      // r0 written in the same cycle it is read: stays zero, no stall; disabled lane zeroed
      set_wb(0, 1'b1, 0, 32'hFFFF);
      clear_group();
      set_lane(0, 1'b1, 0, 0, 2'd0, 2'd1, 32'h50, 32'h7, 64'h1111, 32'h0, 32'h7);
      set_lane(1, 1'b0, 3, 4, 2'd1, 2'd1, 32'h55, 32'h9, 64'h3333, 32'h0, 32'h0);
      accept_group("r0_read");
      wb_en = '0;

      // Both ports write r7 in one cycle; port 1 must win
      set_wb(0, 1'b1, 7, 32'hA);
      set_wb(1, 1'b1, 7, 32'hB);
      clear_group();
      set_lane(0, 1'b1, 0, 0, 2'd2, 2'd1, 32'h0, 32'h5, 64'h4444, 32'h0, 32'h5);
      set_lane(1, 1'b1, 0, 7, 2'd1, 2'd0, 32'h300, 32'h0, 64'h5555, 32'h300, 32'hB);
`ifdef RF_BYPASS_EN
      accept_group("r7_bypass");
      wb_en = '0;
`else
      in_valid = 1'b1;
      #1 check("r7 hazard in_ready", 256'(in_ready), 256'(1'b0));
      tick();
      check("r7 hazard no capture", 256'(out_valid), 256'(1'b0));
      wb_en = '0;
      accept_group("r7_after_hazard");
`endif
      clear_group();
      set_lane(0, 1'b1, 7, 0, 2'd0, 2'd2, 32'h10, 32'h0, 64'h6666, 32'hB, 32'h2);
      accept_group("r7_later");

      // Backpressure: A held for three cycles while B waits
      tick();
      out_ready = 1'b0;
      clear_group();
      set_lane(0, 1'b1, 5, 0, 2'd0, 2'd1, 32'h20, 32'h3, 64'h7777, 32'h11, 32'h3);
      held = exp_grp;
      accept_group("stall_a");
      clear_group();
      set_lane(0, 1'b1, 0, 0, 2'd1, 2'd1, 32'h400, 32'h8, 64'h8888, 32'h400, 32'h8);
      set_lane(1, 1'b1, 0, 0, 2'd2, 2'd2, 32'h404, 32'h0, 64'h9999, 32'h0, 32'h2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall in_ready",  256'(in_ready),    256'(1'b0));
         check("stall out_valid", 256'(out_valid),   256'(1'b1));
         check("stall out_op1",   256'(out_op1),     256'(held.op1));
         check("stall out_pc",    256'(out_pc),      256'(held.pc));
         check("stall payload",   256'(out_payload), 256'(held.payload));
         tick();
      end
      out_ready = 1'b1;
      accept_group("stall_b");

      // Flush with a valid output and a pending group; write in the flush cycle sticks
      flush = 1'b1;
      in_valid = 1'b1;
      set_wb(0, 1'b1, 9, 32'h99);
      #1 check("flush in_ready", 256'(in_ready), 256'(1'b0));
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      wb_en = '0;
      check("flush out_valid",   256'(out_valid),   256'(1'b0));
      check("flush out_lane_en", 256'(out_lane_en), 256'(0));
      clear_group();
      set_lane(0, 1'b1, 9, 0, 2'd0, 2'd1, 32'h30, 32'h1, 64'hAAAA, 32'h99, 32'h1);
      accept_group("r9_read");

      // Reset mid-stream with a held output; the write in the reset cycle is dropped
      tick();
      out_ready = 1'b0;
      clear_group();
      set_lane(0, 1'b1, 5, 0, 2'd0, 2'd1, 32'h40, 32'h2, 64'hBBBB, 32'h11, 32'h2);
      accept_group("pre_rst");
      rst = 1'b1;
      in_valid = 1'b1;
      set_wb(0, 1'b1, 6, 32'h66);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      wb_en = '0;
      out_ready = 1'b1;
      check("rst2 out_valid",   256'(out_valid),   256'(1'b0));
      check("rst2 out_lane_en", 256'(out_lane_en), 256'(0));
      check("rst2 out_op1",     256'(out_op1),     256'(0));
      check("rst2 out_op2",     256'(out_op2),     256'(0));
      check("rst2 out_pc",      256'(out_pc),      256'(0));
      check("rst2 out_imm",     256'(out_imm),     256'(0));
      check("rst2 out_payload", 256'(out_payload), 256'(0));
      check("rst2 out_rj",      256'(out_rj),      256'(0));
      clear_group();
      set_lane(0, 1'b1, 5, 6, 2'd0, 2'd0, 32'h0, 32'h0, 64'hCCCC, 32'h0, 32'h0);
      accept_group("post_rst_read");

      check("sb drained", 256'(sb_q.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
